// File: rtl/mem_stage_wbuf.sv
// -----------------------------------------------------------------------------
// mem_stage_wbuf
//
// Pipeline memory stage sitting between EXE/MEM and MEM/WB. Stores are posted
// into a small circular write buffer and drained to an external SRAM in the
// background. Loads are served from the buffer when they hit (youngest
// matching entry wins) or by a WAIT_CYCLES SRAM read when they miss. The
// pipeline is frozen (ready = 0) only on a load miss or a store into a full
// buffer.
//
// Ports
//   clk, rst                           clock, synchronous active-high reset
//   wb_en_in, mem_r_en_in, mem_w_en_in control bits from EXE/MEM
//   alu_result                         byte address (or plain ALU result)
//   rm_val                             store data
//   dest_in                            destination register
//   wb_en, mem_r_en, mem_w_en,
//   alu_result_out, dest               zero-latency copies of the inputs
//   data_memory_out                    load data (forwarded or registered)
//   sram_dq                            SRAM data bus, driven only while writing
//   sram_w_en                          SRAM write enable, active-low
//   sram_address                       SRAM word address
//   ready                              1 = stage may advance, 0 = freeze
// -----------------------------------------------------------------------------
module mem_stage_wbuf #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 17,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5,
    parameter int WB_DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en_in,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic [DATA_W-1:0]      rm_val,
    input  logic [3:0]             dest_in,
    output logic                   wb_en,
    output logic                   mem_r_en,
    output logic                   mem_w_en,
    output logic [DATA_W-1:0]      alu_result_out,
    output logic [3:0]             dest,
    output logic [DATA_W-1:0]      data_memory_out,
    inout  wire  [DATA_W-1:0]      sram_dq,
    output logic                   sram_w_en,
    output logic [SRAM_ADDR_W-1:0] sram_address,
    output logic                   ready
);

    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_DEPTH + 1);
    localparam int CYC_W = $clog2(WAIT_CYCLES);
    localparam logic [CYC_W-1:0] LAST_CNT = CYC_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

    // Write buffer
    logic [SRAM_ADDR_W-1:0] buf_addr_q [WB_DEPTH];
    logic [DATA_W-1:0]      buf_data_q [WB_DEPTH];
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full, empty, push, pop;

    // Forwarding search
    logic                   fwd_hit;
    logic [DATA_W-1:0]      fwd_data;
    logic [PTR_W-1:0]       scan_idx;

    // SRAM access FSM and its registered outputs
    state_e                 state_q;
    logic [CYC_W-1:0]       cnt_q;
    logic                   ld_done_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [DATA_W-1:0]      dq_out_q;
    logic                   dq_oe_q;
    logic                   sram_w_en_q;
    logic [SRAM_ADDR_W-1:0] sram_addr_q;

    logic [SRAM_ADDR_W-1:0] waddr;
    logic                   load_miss;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == WB_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign waddr = SRAM_ADDR_W'((alu_result - DATA_W'(BASE_ADDR)) >> 2);

    assign full  = (count_q == CNT_W'(WB_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = (state_q == S_WRITE) && (cnt_q == LAST_CNT);
    // A store arriving together with a load is dropped; a full buffer still
    // accepts the store in the very cycle the head entry retires.
    assign push  = mem_w_en_in && !mem_r_en_in && (!full || pop);

    assign head_d  = pop  ? ptr_inc(head_q) : head_q;
    assign tail_d  = push ? ptr_inc(tail_q) : tail_q;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Scan oldest to youngest so the last match, i.e. the youngest store to
    // this word, is the one forwarded.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = head_q;
        for (int i = 0; i < WB_DEPTH; i++) begin
            scan_idx = PTR_W'((int'(head_q) + i) % WB_DEPTH);
            if (i < int'(count_q) && buf_addr_q[scan_idx] == waddr) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[scan_idx];
            end
        end
    end

    // ld_done_q masks the load that has just completed so it does not start a
    // second read while it is still presented during its release cycle.
    assign load_miss = mem_r_en_in && !fwd_hit && !ld_done_q;

    always_comb begin
        ready = 1'b1;
        if (mem_r_en_in) begin
            ready = fwd_hit || ld_done_q;
        end else if (mem_w_en_in) begin
            ready = !full || pop;
        end
    end

    // NOTE: buffer storage has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[tail_q] <= waddr;
            buf_data_q[tail_q] <= rm_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // The IDLE cycle that launches a read counts as access cycle 0, so READ
    // starts its counter at 1 and the load is released WAIT_CYCLES cycles
    // after it arrived. A drain keeps its IDLE cycle separate, giving one
    // entry every WAIT_CYCLES+1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ld_done_q   <= 1'b0;
            rdata_q     <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            sram_w_en_q <= 1'b1;
            sram_addr_q <= '0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (load_miss) begin
                        state_q     <= S_READ;
                        cnt_q       <= CYC_W'(1);
                        sram_addr_q <= waddr;
                    end else if (!empty) begin
                        state_q     <= S_WRITE;
                        cnt_q       <= '0;
                        sram_addr_q <= buf_addr_q[head_q];
                        dq_out_q    <= buf_data_q[head_q];
                        dq_oe_q     <= 1'b1;
                        sram_w_en_q <= 1'b0;
                    end
                end
                S_READ: begin
                    if (cnt_q == LAST_CNT) begin
                        rdata_q   <= sram_dq;
                        ld_done_q <= 1'b1;
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    // Write enable rises one cycle before the bus is
                    // released so data is held across the rising edge.
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= S_IDLE;
                        cnt_q       <= '0;
                        dq_oe_q     <= 1'b0;
                        sram_w_en_q <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
                        sram_w_en_q <= (cnt_q + 1'b1 == LAST_CNT);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sram_dq      = dq_oe_q ? dq_out_q : 'z;
    assign sram_w_en    = sram_w_en_q;
    assign sram_address = sram_addr_q;

    assign data_memory_out = (mem_r_en_in && fwd_hit) ? fwd_data : rdata_q;

    assign wb_en          = wb_en_in;
    assign mem_r_en       = mem_r_en_in;
    assign mem_w_en       = mem_w_en_in;
    assign alu_result_out = alu_result;
    assign dest           = dest_in;

endmodule
